frv_core_fetch_buffer: RTL and testbench

//  Decoupling FIFO between the fetch stage and the decode stage. Accepts

---
 rtl/frv_core_fetch_buffer.sv | 92 +++++++++
 tb/tb_frv_core_fetch_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/frv_core_fetch_buffer.sv
// ============================================================================
//  Module   : frv_core_fetch_buffer
//  Brief    : Fetch-to-decode decoupling FIFO, emptied by control flow changes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frv_core_fetch_buffer #(
  parameter int RLEN  = 33,
  parameter int DEPTH = 2
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic                     flush,
  input  logic [RLEN-1:0]          f_data,
  input  logic                     f_valid,
  output logic                     f_ready,
  output logic [RLEN-1:0]          p_data,
  output logic [RLEN-1:0]          d_data,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [RLEN-1:0]    r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [RLEN-1:0]    r_p_data;

  logic w_push;
  logic w_pop;

  // Handshakes depend only on registered state, keeping fetch/decode timing apart.
  assign f_ready = (r_count != c_CNT_W'(DEPTH));
  assign d_valid = (r_count != '0);
  assign d_data  = r_mem[r_rd_ptr];
  assign p_data  = r_p_data;
  assign count   = r_count;

  assign w_push = f_valid && f_ready && !flush;
  assign w_pop  = d_valid && d_ready && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
        r_mem[i] <= '0;
      end else if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
        r_mem[i] <= f_data;
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Realignment word survives flushes; only an accepted push replaces it.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_p_data <= '0;
    end else if (w_push) begin
      r_p_data <= f_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frv_core_fetch_buffer.sv
// ============================================================================
//  Module   : tb_frv_core_fetch_buffer
//  Brief    : Scoreboard bench for the fetch buffer, directed then random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frv_core_fetch_buffer;

  localparam int RLEN  = 33;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [RLEN-1:0] f_data;
  logic            f_valid;
  logic            f_ready;
  logic [RLEN-1:0] p_data;
  logic [RLEN-1:0] d_data;
  logic            d_valid;
  logic            d_ready;
  logic [$clog2(DEPTH):0] count;

  frv_core_fetch_buffer #(.RLEN(RLEN), .DEPTH(DEPTH)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .flush   (flush),
    .f_data  (f_data),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .p_data  (p_data),
    .d_data  (d_data),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .count   (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected contents of the buffer, oldest first, and the expected realignment word.
  logic [RLEN-1:0] sb_q [$];
  logic [RLEN-1:0] model_p  = '0;
  logic            exp_room = 1'b1;
  int              mon_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: acceptance of a fetch word is decided from the queue occupancy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      model_p = '0;
    end else if (flush) begin
      sb_q.delete();
    end else if (f_valid && exp_room) begin
      sb_q.push_back(f_data);
      model_p = f_data;
    end
  end

  // Monitor: mid-cycle comparison of every output, popping on an accepted decode handshake.
  always @(negedge clk) begin
    if (!rst) begin
      mon_n = sb_q.size();
      chk("count",   64'(count),   64'(mon_n));
      chk("d_valid", 64'(d_valid), 64'(mon_n != 0));
      chk("f_ready", 64'(f_ready), 64'(mon_n != DEPTH));
      chk("p_data",  64'(p_data),  64'(model_p));
      exp_room = (mon_n != DEPTH);
      if (mon_n != 0) begin
        chk("d_data", 64'(d_data), 64'(sb_q[0]));
        if (d_ready && !flush) begin
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic fv, input logic [RLEN-1:0] fd, input logic dr, input logic fl);
    f_valid = fv;
    f_data  = fd;
    d_ready = dr;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    f_valid = 1'b0;
    f_data  = '0;
    d_ready = 1'b0;
    #2;
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_f_ready", 64'(f_ready), 64'd1);
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_d_data",  64'(d_data),  64'd0);
    chk("rst_p_data",  64'(p_data),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single push becomes visible the following cycle.
    drive(1'b1, 33'h0_00000013, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Fill to capacity, then hold an extra word that must never be stored.
    drive(1'b1, 33'h0_0000000A, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000000B, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000000C, 1'b0, 1'b0);
    drive(1'b1, 33'h0_0000000C, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Steady-state push and pop at count 1, wrapping the pointers.
    drive(1'b1, 33'h0_00000050, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, RLEN'(i), 1'b1, 1'b0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, with competing push and pop.
    drive(1'b1, 33'h1_00000061, 1'b0, 1'b0);
    drive(1'b1, 33'h0_00000062, 1'b0, 1'b0);
    drive(1'b1, 33'h0_00000063, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {1'($urandom_range(0, 1)), 32'($urandom)},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between clock edges while one error-flagged word is held.
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 33'h1_DEADBEEF, 1'b0, 1'b0);
    f_valid = 1'b0;
    f_data  = '0;
    @(negedge clk);
    #1;
    chk("err_bit_held", 64'(d_data[RLEN-1]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_d_valid", 64'(d_valid), 64'd0);
    chk("async_count",   64'(count),   64'd0);
    chk("async_p_data",  64'(p_data),  64'd0);
    chk("async_f_ready", 64'(f_ready), 64'd1);
    chk("async_d_data",  64'(d_data),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 33'h0_00000077, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
